video_timing_tx: RTL and testbench

VIDEO_TIMING_TX -- requirements
Module: video_timing_tx

---
 rtl/video_timing_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_video_timing_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_tx.sv
// video_timing_tx
//   Generates video raster timing (DE/HS/VS) and streams pixels from a small
//   input FIFO onto a registered parallel video bus.
//
//   Ports:
//     clk          single clock, all logic on the rising edge
//     rst_n        synchronous active-low reset
//     en           transmit enable; dropping it finishes the current frame
//     pix_data     pixel {R,G,B}, 8 bits per channel
//     pix_valid    pix_data/pix_sof valid
//     pix_sof      marks the first pixel of a frame
//     pix_ready    block accepts the presented word this cycle
//     DPo          {VS,HS,DE,R,G,B}; registered one clock after the counters
//     underrun     sticky flag: an active pixel found the FIFO empty
//     frame_start  one-cycle pulse together with DE of pixel (0,0)
//
//   Build option: define VIDEO_TIMING_TX_COLORBAR_EN to replace the FIFO
//   stream with eight vertical colour bars (white, yellow, cyan, green,
//   magenta, red, blue, black).

module video_timing_tx #(
  parameter int H_ACT  = 1920,
  parameter int H_FP   = 88,
  parameter int H_SYNC = 44,
  parameter int H_BP   = 148,
  parameter int V_ACT  = 1080,
  parameter int V_FP   = 4,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 36
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_sof,
  output logic        pix_ready,
  output logic [26:0] DPo,
  output logic        underrun,
  output logic        frame_start
);

  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_ACT_L    = HW'(H_ACT);
  localparam logic [HW-1:0] H_HS_START = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_HS_END   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT_L    = VW'(V_ACT);
  localparam logic [VW-1:0] V_VS_START = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_VS_END   = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOT - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [24:0]     fifo_mem_q [4];
  logic [24:0]     fifo_mem_d [4];
  logic [1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]      rd_ptr_q, rd_ptr_d;
  logic [2:0]      count_q, count_d;
  logic [26:0]     dpo_q, dpo_d;
  logic            underrun_q, underrun_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_ur_q, frame_ur_d;

  logic            de, hs, vs;
  logic            fifo_empty, fifo_full;
  logic            push, pop;
  logic [24:0]     fifo_head;

  assign de = (h_cnt_q < H_ACT_L) && (v_cnt_q < V_ACT_L);
  assign hs = (h_cnt_q >= H_HS_START) && (h_cnt_q < H_HS_END);
  assign vs = (v_cnt_q >= V_VS_START) && (v_cnt_q < V_VS_END);

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];

`ifdef VIDEO_TIMING_TX_COLORBAR_EN
  // Pixels come from the bar generator, so the input side is closed.
  assign pix_ready = 1'b0;

  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  // Bar k starts at ceil(k*H_ACT/8), i.e. bar index = floor(8*h/H_ACT).
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt_q >= HW'((k * H_ACT + 7) / 8)) bar_idx = 3'(k);
    end
  end

  // Bar order W,Y,C,G,M,R,B,K: R off for idx bit1, G off for bit2, B off for bit0.
  assign bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
`else
  assign pix_ready = !fifo_full && (state_q != IDLE);
`endif

  assign push = pix_valid && pix_ready;

  // Sequencer: raster counters, FIFO pops and the next DPo word.
  always_comb begin
    state_d       = state_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    pop           = 1'b0;
    dpo_d         = '0;
    frame_start_d = 1'b0;
    underrun_d    = underrun_q;
    frame_ur_d    = frame_ur_q;

    case (state_q)
      IDLE: begin
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        frame_ur_d = 1'b0;
        if (en) state_d = ALIGN;
      end

      ALIGN: begin
        h_cnt_d    = '0;
        v_cnt_d    = '0;
        frame_ur_d = 1'b0;
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
        state_d = RUN;
`else
        // Drop words until a start-of-frame word sits at the head; it is
        // left in the FIFO so it becomes pixel (0,0).
        if (!fifo_empty) begin
          if (fifo_head[24]) state_d = RUN;
          else               pop     = 1'b1;
        end
`endif
      end

      RUN: begin
        dpo_d[26:24]  = {vs, hs, de};
        frame_start_d = de && (h_cnt_q == '0) && (v_cnt_q == '0);
        if (de) begin
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
          dpo_d[23:0] = bar_rgb;
`else
          if (!fifo_empty) begin
            pop         = 1'b1;
            dpo_d[23:0] = fifo_head[23:0];
          end else begin
            underrun_d = 1'b1;
            frame_ur_d = 1'b1;
          end
`endif
        end

        if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          if (v_cnt_q == V_LAST) begin
            v_cnt_d    = '0;
            frame_ur_d = 1'b0;
            // Frame boundary: the only point where RUN can be left.
            if (!en)             state_d = IDLE;
            else if (frame_ur_q) state_d = ALIGN;
          end else begin
            v_cnt_d = v_cnt_q + 1'b1;
          end
        end else begin
          h_cnt_d = h_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; push and pop in the same cycle leave the count unchanged.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = {pix_sof, pix_data};
      wr_ptr_d             = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      for (int i = 0; i < 4; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dpo_q         <= '0;
      underrun_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_ur_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fifo_mem_q    <= fifo_mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dpo_q         <= dpo_d;
      underrun_q    <= underrun_d;
      frame_start_q <= frame_start_d;
      frame_ur_q    <= frame_ur_d;
    end
  end

  assign DPo         = dpo_q;
  assign underrun    = underrun_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_tx.sv
// tb_video_timing_tx
//   Drives video_timing_tx with a small raster (8+2+2+2 x 4+1+1+1) and
//   compares every cycle against a frame-position/queue reference model.
//   Build option VIDEO_TIMING_TX_COLORBAR_EN switches the model to bars.

module tb_video_timing_tx;

  localparam int H_ACT  = 8;
  localparam int H_FP   = 2;
  localparam int H_SYNC = 2;
  localparam int H_BP   = 2;
  localparam int V_ACT  = 4;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 1;
  localparam int V_BP   = 1;
  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [26:0] DPo;
  logic        underrun;
  logic        frame_start;

  video_timing_tx #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pix_data(pix_data),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .DPo(DPo),
    .underrun(underrun),
    .frame_start(frame_start)
  );

  typedef struct packed {
    logic        ready;
    logic        fs;
    logic        ur;
    logic [26:0] dpo;
  } exp_t;

  exp_t        sb[$];
  logic [24:0] src[$];
  int          total = 0;
  int          bad = 0;
  int          de_seen = 0;
  bit          ready_at_drive = 0;

  logic [23:0] bar_colors [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                  24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [26:0] got, input logic [26:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s at t=%0t: got=%h expected=%h", name, $time, got, want);
    end
  endtask

  // Reference model: mode 0 idle, 1 waiting for sof, 2 streaming; the
  // raster is a linear position 0..FRAME-1 and the FIFO a queue.
  int          m_mode = 0;
  int          m_pos = 0;
  logic [24:0] m_fifo[$];
  bit          m_ur = 0;
  bit          m_bad = 0;
  int          m_h, m_v;
  bit          m_de, m_hs, m_vs, m_push;
  logic [24:0] m_w;
  exp_t        m_e;

  always @(posedge clk) begin
    m_e = '0;
    if (!rst_n) begin
      m_mode = 0;
      m_pos  = 0;
      m_fifo.delete();
      m_ur   = 0;
      m_bad  = 0;
    end else begin
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
      m_push = 0;
`else
      m_push = pix_valid && (m_mode != 0) && (m_fifo.size() < 4);
`endif
      case (m_mode)
        0: if (en) m_mode = 1;
        1: begin
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
          m_mode = 2;
          m_pos  = 0;
`else
          if (m_fifo.size() > 0) begin
            m_w = m_fifo[0];
            if (m_w[24]) begin
              m_mode = 2;
              m_pos  = 0;
            end else begin
              void'(m_fifo.pop_front());
            end
          end
`endif
        end
        default: begin
          m_h  = m_pos % H_TOT;
          m_v  = m_pos / H_TOT;
          m_de = (m_h < H_ACT) && (m_v < V_ACT);
          m_hs = (m_h >= H_ACT + H_FP) && (m_h < H_ACT + H_FP + H_SYNC);
          m_vs = (m_v >= V_ACT + V_FP) && (m_v < V_ACT + V_FP + V_SYNC);
          m_e.dpo[26:24] = {m_vs, m_hs, m_de};
          if (m_de) begin
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
            m_e.dpo[23:0] = bar_colors[(m_h * 8) / H_ACT];
`else
            if (m_fifo.size() > 0) begin
              m_w = m_fifo.pop_front();
              m_e.dpo[23:0] = m_w[23:0];
            end else begin
              m_ur  = 1;
              m_bad = 1;
            end
`endif
          end
          m_e.fs = m_de && (m_pos == 0);
          m_pos++;
          if (m_pos == FRAME) begin
            m_pos = 0;
            if (!en)       m_mode = 0;
            else if (m_bad) m_mode = 1;
            m_bad = 0;
          end
        end
      endcase
      if (m_push) m_fifo.push_back({pix_sof, pix_data});
    end
    m_e.ur = m_ur;
`ifdef VIDEO_TIMING_TX_COLORBAR_EN
    m_e.ready = 1'b0;
`else
    m_e.ready = (m_mode != 0) && (m_fifo.size() < 4);
`endif
    sb.push_back(m_e);
  end

  // Monitor: DPo and flags are stable at the falling edge.
  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checkOutput("DPo", DPo, mon_e.dpo);
      checkOutput("underrun", {26'b0, underrun}, {26'b0, mon_e.ur});
      checkOutput("frame_start", {26'b0, frame_start}, {26'b0, mon_e.fs});
      checkOutput("pix_ready", {26'b0, pix_ready}, {26'b0, mon_e.ready});
      if (DPo[24] === 1'b1) de_seen++;
    end
  end

  // Presents the head of src, holding it until the DUT has accepted it.
  task automatic applyStimulus(input int n, input int valid_pct);
    repeat (n) begin
      @(negedge clk);
      if (pix_valid && ready_at_drive && src.size() > 0) void'(src.pop_front());
      ready_at_drive = pix_ready && rst_n;
      if (src.size() > 0 && $urandom_range(99) < valid_pct) begin
        pix_valid = 1'b1;
        {pix_sof, pix_data} = src[0];
      end else begin
        pix_valid = 1'b0;
        pix_sof   = 1'($urandom_range(1));
        pix_data  = 24'($urandom);
      end
    end
  endtask

  task automatic fillStream(input int base, input int n, input int sof_every);
    for (int i = 0; i < n; i++)
      src.push_back({1'((sof_every > 0) && (i % sof_every == 0)), 24'(base + i)});
  endtask

  task automatic resetDut();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    src.delete();
    applyStimulus(2, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    applyStimulus(3, 0);
    rst_n = 1'b1;

    $display("[TB] continuous stream from 0x000001");
    fillStream(1, 96, 32);
    en = 1'b1;
    applyStimulus(2 * FRAME + 20, 100);

    $display("[TB] non-sof words ahead of 0xABCDEF");
    resetDut();
    src.push_back({1'b0, 24'h111111});
    src.push_back({1'b0, 24'h222222});
    src.push_back({1'b0, 24'h333333});
    src.push_back({1'b1, 24'hABCDEF});
    fillStream(2, 31, 0);
    applyStimulus(FRAME + 30, 100);

    $display("[TB] starvation after five pixels");
    resetDut();
    fillStream(1, 5, 32);
    applyStimulus(FRAME + 20, 100);
    fillStream(24'h100, 64, 32);
    applyStimulus(2 * FRAME + 30, 100);

    $display("[TB] enable dropped mid-frame");
    resetDut();
    fillStream(24'h200, 64, 32);
    applyStimulus(40, 100);
    en = 1'b0;
    applyStimulus(FRAME + 20, 100);

    $display("[TB] reset in the middle of a line");
    en = 1'b1;
    fillStream(24'h300, 64, 32);
    applyStimulus(60, 100);
    resetDut();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 800; i++) begin
      rst_n = ($urandom_range(299) != 0);
      if ($urandom_range(199) == 0) en = ~en;
      if (src.size() < 4) src.push_back({1'($urandom_range(19) == 0), 24'($urandom)});
      applyStimulus(1, 70);
    end
    rst_n = 1'b1;
    applyStimulus(4, 0);

    checkOutput("de_activity", {26'b0, 1'(de_seen > 150)}, 27'd1);
    checkOutput("scoreboard_drain", {26'b0, 1'(sb.size() <= 1)}, 27'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
